// File: rtl/parser_pkg.sv
// parser_pkg: shared field positions, encodings, sizes and FSM state for the
// PHV builder and its per-action extract units.
package parser_pkg;

  // parse-action field positions
  localparam int ACT_OFF_MSB  = 15;
  localparam int ACT_OFF_LSB  = 7;
  localparam int ACT_TYPE_MSB = 6;
  localparam int ACT_TYPE_LSB = 5;
  localparam int ACT_IDX_MSB  = 4;
  localparam int ACT_IDX_LSB  = 2;
  localparam int ACT_RSVD_BIT = 1;
  localparam int ACT_EN_BIT   = 0;

  // container type encodings
  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_2B   = 2'b01;
  localparam logic [1:0] TYPE_4B   = 2'b10;
  localparam logic [1:0] TYPE_6B   = 2'b11;

  // container sizes in bytes
  localparam int SIZE_2B = 2;
  localparam int SIZE_4B = 4;
  localparam int SIZE_6B = 6;

  // metadata layout; VLAN source bit offset inside the header window
  localparam int META_WIDTH    = 256;
  localparam int META_PORT_LSB = 24;
  localparam int META_TU_LSB   = 32;
  localparam int META_VLAN_LSB = 129;
  localparam int VLAN_SRC_OFF  = 116;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  function automatic int type_size(input logic [1:0] t);
    case (t)
      TYPE_2B: return SIZE_2B;
      TYPE_4B: return SIZE_4B;
      TYPE_6B: return SIZE_6B;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/parser_extract_unit.sv
// parser_extract_unit: decodes one parse action, validates it against the
// container counts and window size, and pulls the big-endian field out of the
// header window, right-aligned in a 48-bit value.
module parser_extract_unit #(
  parameter int C_WIN_BYTES          = 512,
  parameter int C_WIDTH_PARSE_ACTION = 16,
  parameter int C_NUM_2B             = 8,
  parameter int C_NUM_4B             = 8,
  parameter int C_NUM_6B             = 8
) (
  input  logic [C_WIDTH_PARSE_ACTION-1:0] action,
  input  logic [C_WIN_BYTES*8-1:0]        window,
  output logic                            wr_en,
  output logic [1:0]                      wr_type,
  output logic [2:0]                      wr_idx,
  output logic [47:0]                     wr_val
);
  import parser_pkg::*;

  localparam int BI_W = $clog2(C_WIN_BYTES*8);

  logic [8:0]      off;
  logic [1:0]      typ;
  logic [2:0]      idx;
  logic            en;
  logic            unused_rsvd;
  int              sz;
  int              cnt;
  logic [47:0]     raw;
  logic [BI_W-1:0] bit_idx;

  assign off         = action[ACT_OFF_MSB:ACT_OFF_LSB];
  assign typ         = action[ACT_TYPE_MSB:ACT_TYPE_LSB];
  assign idx         = action[ACT_IDX_MSB:ACT_IDX_LSB];
  assign en          = action[ACT_EN_BIT];
  assign unused_rsvd = action[ACT_RSVD_BIT];

  // gather six bytes from the offset (first byte at the MSB), then shift the
  // unused tail away so the field ends right-aligned
  always_comb begin
    sz      = type_size(typ);
    cnt     = (typ == TYPE_2B) ? C_NUM_2B : (typ == TYPE_4B) ? C_NUM_4B :
              (typ == TYPE_6B) ? C_NUM_6B : 0;
    raw     = '0;
    bit_idx = '0;
    for (int j = 0; j < 6; j++) begin
      bit_idx = BI_W'((int'(off) + j) * 8);
      if (int'(off) + j < C_WIN_BYTES) raw[47-8*j -: 8] = window[bit_idx +: 8];
    end
    wr_val  = raw >> (8 * (6 - sz));
    wr_en   = en && (typ != TYPE_NONE) && (int'(idx) < cnt) &&
              (int'(off) + sz <= C_WIN_BYTES);
    wr_type = typ;
    wr_idx  = idx;
  end

endmodule

// File: rtl/parser_phv_builder.sv
// parser_phv_builder: walks a packet's parse actions K per cycle over a held
// header window, fills 2B/4B/6B container banks and emits the PHV with
// ready/valid back-pressure. Optional VLAN side channel: PARSER_VLAN_OUT_EN.
module parser_phv_builder #(
  parameter int         C_AXIS_DATA_WIDTH    = 256,
  parameter int         C_AXIS_TUSER_WIDTH   = 128,
  parameter int         C_NUM_SEGS           = 16,
  parameter int         C_NUM_PARSE_ACTION   = 64,
  parameter int         C_WIDTH_PARSE_ACTION = 16,
  parameter int         C_ACTS_PER_CYCLE     = 4,
  parameter int         C_NUM_2B             = 8,
  parameter int         C_NUM_4B             = 8,
  parameter int         C_NUM_6B             = 8,
  parameter int         C_VLANID_WIDTH       = 12,
  parameter logic [7:0] C_DEFAULT_OUT_PORT   = 8'h04,
  parameter int         PKT_HDR_LEN          = 48*C_NUM_6B + 32*C_NUM_4B + 16*C_NUM_2B + 256
) (
  input  logic                                          axis_clk,
  input  logic                                          aresetn,
  input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]       tdata_segs,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]                 tuser_1st,
  input  logic [C_NUM_PARSE_ACTION*C_WIDTH_PARSE_ACTION-1:0] bram_out,
  input  logic                                          segs_valid,
  output logic                                          segs_ready,
  output logic                                          parser_valid,
  output logic [PKT_HDR_LEN-1:0]                        pkt_hdr_vec,
  input  logic                                          stg_ready_in,
  output logic [C_VLANID_WIDTH-1:0]                     out_vlan,
  output logic                                          out_vlan_valid,
  input  logic                                          out_vlan_ready
);
  import parser_pkg::*;

  localparam int K         = C_ACTS_PER_CYCLE;
  localparam int NSTEPS    = C_NUM_PARSE_ACTION / K;
  localparam int STEP_W    = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int AI_W      = $clog2(C_NUM_PARSE_ACTION);
  localparam int WIN_BYTES = C_NUM_SEGS * C_AXIS_DATA_WIDTH / 8;
  localparam int META_PAD  = META_WIDTH - META_VLAN_LSB - C_VLANID_WIDTH;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  state_e                   state_q, state_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic                     phv_done_q, phv_done_d;
  logic                     vlan_done_q, vlan_done_d;
  logic [C_NUM_2B-1:0][15:0] c2_q, c2_d;
  logic [C_NUM_4B-1:0][31:0] c4_q, c4_d;
  logic [C_NUM_6B-1:0][47:0] c6_q, c6_d;
  logic [META_WIDTH-1:0]    meta_q, meta_d;
  logic                     phv_ok, vlan_ok;

  logic [C_NUM_PARSE_ACTION-1:0][C_WIDTH_PARSE_ACTION-1:0] act_list;
  logic [K-1:0]             wr_en;
  logic [K-1:0][1:0]        wr_type;
  logic [K-1:0][2:0]        wr_idx;
  logic [K-1:0][47:0]       wr_val;
  logic                     unused_ok;

  assign act_list    = bram_out;
  assign pkt_hdr_vec = {c6_q, c4_q, c2_q, meta_q};
  assign unused_ok   = &{1'b0, tuser_1st[META_TU_LSB-1:META_PORT_LSB], out_vlan_ready, vlan_done_q};

  // action i lives in slot N-1-i; lane u handles action step*K+u
  for (genvar u = 0; u < K; u++) begin : g_unit
    logic [AI_W-1:0] slot;
    assign slot = AI_W'(C_NUM_PARSE_ACTION - 1 - (int'(step_q) * K + u));
    parser_extract_unit #(
      .C_WIN_BYTES          (WIN_BYTES),
      .C_WIDTH_PARSE_ACTION (C_WIDTH_PARSE_ACTION),
      .C_NUM_2B             (C_NUM_2B),
      .C_NUM_4B             (C_NUM_4B),
      .C_NUM_6B             (C_NUM_6B)
    ) u_ext (
      .action  (act_list[slot]),
      .window  (tdata_segs),
      .wr_en   (wr_en[u]),
      .wr_type (wr_type[u]),
      .wr_idx  (wr_idx[u]),
      .wr_val  (wr_val[u])
    );
  end

  // FSM state register
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      phv_done_q  <= 1'b0;
      vlan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      phv_done_q  <= phv_done_d;
      vlan_done_q <= vlan_done_d;
    end
  end

  // next state: each EMIT handshake is remembered until both are done
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    phv_done_d  = phv_done_q;
    vlan_done_d = vlan_done_q;
    phv_ok      = phv_done_q | stg_ready_in;
`ifdef PARSER_VLAN_OUT_EN
    vlan_ok     = vlan_done_q | out_vlan_ready;
`else
    vlan_ok     = 1'b1;
`endif
    case (state_q)
      ST_IDLE: if (segs_valid) begin
        state_d = ST_WALK;
        step_d  = '0;
      end
      ST_WALK: begin
        if (step_q == LAST_STEP) state_d = ST_EMIT;
        else                     step_d  = step_q + 1'b1;
      end
      ST_EMIT: begin
        phv_done_d  = phv_ok;
        vlan_done_d = vlan_ok;
        if (phv_ok && vlan_ok) begin
          state_d     = ST_IDLE;
          phv_done_d  = 1'b0;
          vlan_done_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs decoded from state; cleared immediately by reset
  always_comb begin
    segs_ready     = (state_q == ST_WALK) && (step_q == LAST_STEP);
    parser_valid   = (state_q == ST_EMIT) && !phv_done_q;
`ifdef PARSER_VLAN_OUT_EN
    out_vlan_valid = (state_q == ST_EMIT) && !vlan_done_q;
    out_vlan       = meta_q[META_VLAN_LSB +: C_VLANID_WIDTH];
`else
    out_vlan_valid = 1'b0;
    out_vlan       = '0;
`endif
  end

  // container banks and metadata registers
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      c2_q   <= '0;
      c4_q   <= '0;
      c6_q   <= '0;
      meta_q <= '0;
    end else begin
      c2_q   <= c2_d;
      c4_q   <= c4_d;
      c6_q   <= c6_d;
      meta_q <= meta_d;
    end
  end

  // accept clears banks and captures metadata; WALK applies lanes in
  // ascending order so the higher action index wins a shared container
  always_comb begin
    c2_d   = c2_q;
    c4_d   = c4_q;
    c6_d   = c6_q;
    meta_d = meta_q;
    if (state_q == ST_IDLE && segs_valid) begin
      c2_d   = '0;
      c4_d   = '0;
      c6_d   = '0;
      meta_d = {{META_PAD{1'b0}}, tdata_segs[VLAN_SRC_OFF +: C_VLANID_WIDTH], 1'b0,
                tuser_1st[C_AXIS_TUSER_WIDTH-1:META_TU_LSB], C_DEFAULT_OUT_PORT,
                tuser_1st[META_PORT_LSB-1:0]};
    end else if (state_q == ST_WALK) begin
      for (int u = 0; u < K; u++) begin
        if (wr_en[u]) begin
          case (wr_type[u])
            TYPE_2B: c2_d[wr_idx[u]] = wr_val[u][15:0];
            TYPE_4B: c4_d[wr_idx[u]] = wr_val[u][31:0];
            TYPE_6B: c6_d[wr_idx[u]] = wr_val[u];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_parser_phv_builder.sv
// Bench for parser_phv_builder: directed and random packets checked against a
// byte-level reference model of the action list.
`timescale 1ns/1ps
module tb_parser_phv_builder;
  localparam int DW = 256, NSEG = 16, NACT = 64, AW = 16, K = 4;
  localparam int N2 = 6, N4 = 8, N6 = 8, VW = 12;
  localparam int WB = NSEG * DW / 8;
  localparam int PHV_W = 48*N6 + 32*N4 + 16*N2 + 256;
  localparam int B2 = 256, B4 = B2 + 16*N2, B6 = B4 + 32*N4;

  logic                 axis_clk = 1'b0;
  logic                 aresetn = 1'b1;
  logic [NSEG*DW-1:0]   tdata_segs = '0;
  logic [127:0]         tuser_1st = '0;
  logic [NACT*AW-1:0]   bram_out = '0;
  logic                 segs_valid = 1'b0;
  logic                 segs_ready;
  logic                 parser_valid;
  logic [PHV_W-1:0]     pkt_hdr_vec;
  logic                 stg_ready_in = 1'b1;
  logic [VW-1:0]        out_vlan;
  logic                 out_vlan_valid;
  logic                 out_vlan_ready = 1'b1;

  always #5 axis_clk = ~axis_clk;

  parser_phv_builder #(
    .C_NUM_SEGS(NSEG), .C_NUM_PARSE_ACTION(NACT), .C_ACTS_PER_CYCLE(K),
    .C_NUM_2B(N2), .C_NUM_4B(N4), .C_NUM_6B(N6)
  ) dut (
    .axis_clk(axis_clk), .aresetn(aresetn), .tdata_segs(tdata_segs),
    .tuser_1st(tuser_1st), .bram_out(bram_out), .segs_valid(segs_valid),
    .segs_ready(segs_ready), .parser_valid(parser_valid), .pkt_hdr_vec(pkt_hdr_vec),
    .stg_ready_in(stg_ready_in), .out_vlan(out_vlan), .out_vlan_valid(out_vlan_valid),
    .out_vlan_ready(out_vlan_ready)
  );

  logic [7:0]   win  [WB];
  logic [15:0]  acts [NACT];
  logic [127:0] tuser;
  int n_chk = 0, n_err = 0;

`ifdef PARSER_VLAN_OUT_EN
  localparam bit VLAN_EN = 1'b1;
`else
  localparam bit VLAN_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_act(int off, int t, int ix, int en);
    return 16'(off*128 + t*32 + ix*4 + en);
  endfunction

  function automatic logic [VW-1:0] model_vlan();
    logic [15:0] w;
    w = {win[15], win[14]};
    return VW'(w >> 4);
  endfunction

  // apply the action list in order over the byte array; later actions win
  function automatic logic [PHV_W-1:0] model_phv();
    logic [47:0]      cont [3][8];
    int               cnt [3], sz [3], base [3];
    logic [PHV_W-1:0] phv;
    cnt = '{N2, N4, N6}; sz = '{2, 4, 6}; base = '{B2, B4, B6};
    foreach (cont[t, k]) cont[t][k] = '0;
    for (int i = 0; i < NACT; i++) begin
      int off, t, ix, en;
      off = int'(acts[i]) / 128;
      t   = (int'(acts[i]) / 32) % 4;
      ix  = (int'(acts[i]) / 4) % 8;
      en  = int'(acts[i]) % 2;
      if (en == 1 && t != 0 && ix < cnt[t-1] && off + sz[t-1] <= WB) begin
        logic [47:0] v;
        v = '0;
        for (int j = 0; j < sz[t-1]; j++) v = (v << 8) | 48'(win[off+j]);
        cont[t-1][ix] = v;
      end
    end
    phv = PHV_W'(tuser[23:0]) | (PHV_W'(8'h04) << 24) | (PHV_W'(tuser[127:32]) << 32) |
          (PHV_W'(model_vlan()) << 129);
    for (int t = 0; t < 3; t++)
      for (int k = 0; k < cnt[t]; k++)
        phv |= PHV_W'(cont[t][k]) << (base[t] + 8*sz[t]*k);
    return phv;
  endfunction

  task automatic new_pkt();
    for (int b = 0; b < WB; b++) win[b] = 8'($urandom);
    for (int i = 0; i < NACT; i++) acts[i] = '0;
    tuser = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drive();
    for (int b = 0; b < WB; b++) tdata_segs[8*b +: 8] = win[b];
    for (int i = 0; i < NACT; i++) bram_out[(NACT-1-i)*AW +: AW] = acts[i];
    tuser_1st = tuser;
  endtask

  task automatic chk_phv(input string tag, input logic [PHV_W-1:0] exp);
    for (int c = 0; c < (PHV_W + 63) / 64; c++)
      chk($sformatf("%s.w%0d", tag, c), 64'(pkt_hdr_vec >> (64*c)), 64'(exp >> (64*c)));
  endtask

  // count edges (sampling edge = 1) until parser_valid, bounded
  task automatic wait_valid(output int cyc, output int rcnt, output int rat);
    cyc = 0; rcnt = 0; rat = -1;
    while (!parser_valid && cyc < 100) begin
      @(posedge axis_clk); #1;
      cyc++;
      if (segs_ready) begin rcnt++; rat = cyc; end
    end
  endtask

  task automatic run(input string tag);
    logic [PHV_W-1:0] e;
    int cyc, rc, ra;
    e = model_phv();
    drive();
    segs_valid = 1'b1;
    wait_valid(cyc, rc, ra);
    segs_valid = 1'b0;
    chk({tag, ".lat"}, 64'(cyc), 64'd17);
    chk({tag, ".rdy_cnt"}, 64'(rc), 64'd1);
    chk({tag, ".rdy_at"}, 64'(ra), 64'd16);
    chk_phv(tag, e);
    chk({tag, ".ovv"}, 64'(out_vlan_valid), 64'(VLAN_EN));
    chk({tag, ".ov"}, 64'(out_vlan), VLAN_EN ? 64'(model_vlan()) : 64'd0);
    @(posedge axis_clk); #1;
    chk({tag, ".drop"}, 64'(parser_valid), 64'd0);
  endtask

  initial begin
    logic [PHV_W-1:0] ea, eb;
    logic [VW-1:0]    va;
    int cyc, rc, ra;

    new_pkt(); drive();
    #1 aresetn = 1'b0;
    #11;
    chk("rst.pv", 64'(parser_valid), 64'd0);
    chk("rst.sr", 64'(segs_ready), 64'd0);
    chk("rst.ovv", 64'(out_vlan_valid), 64'd0);
    chk("rst.ov", 64'(out_vlan), 64'd0);
    chk_phv("rst", '0);
    @(negedge axis_clk) aresetn = 1'b1;
    @(posedge axis_clk); #1;

    // single 4B extraction
    new_pkt();
    win[26] = 8'hC0; win[27] = 8'hA8; win[28] = 8'h00; win[29] = 8'h01;
    acts[0] = mk_act(26, 2, 0, 1);
    run("t1");
    chk("t1.c4_0", 64'(pkt_hdr_vec[B4 +: 32]), 64'hC0A80001);

    // conflicts across and within a cycle
    new_pkt();
    win[100] = 8'h11; win[101] = 8'h11; win[300] = 8'h22; win[301] = 8'h22;
    acts[5]  = mk_act(100, 1, 3, 1);
    acts[40] = mk_act(300, 1, 3, 1);
    acts[8]  = mk_act(100, 2, 5, 1);
    acts[9]  = mk_act(300, 2, 5, 1);
    run("t2");
    chk("t2.c2_3", 64'(pkt_hdr_vec[B2 + 16*3 +: 16]), 64'h2222);
    chk("t2.c4_5", 64'(pkt_hdr_vec[B4 + 32*5 +: 32]), {32'h0, 8'h22, 8'h22, win[302], win[303]});

    // boundaries: window end, bad index, disabled, type none
    new_pkt();
    acts[0] = mk_act(510, 3, 2, 1);
    acts[1] = mk_act(0, 1, 7, 1);
    acts[2] = mk_act(508, 2, 1, 1);
    acts[3] = mk_act(509, 2, 2, 1);
    acts[4] = mk_act(40, 2, 3, 0);
    acts[5] = mk_act(40, 0, 4, 1);
    acts[6] = mk_act(506, 3, 0, 1);
    run("t3");
    chk("t3.c6_2", 64'(pkt_hdr_vec[B6 + 48*2 +: 48]), 64'd0);
    chk("t3.c4_1", 64'(pkt_hdr_vec[B4 + 32 +: 32]), {32'h0, win[508], win[509], win[510], win[511]});
    chk("t3.c4_2", 64'(pkt_hdr_vec[B4 + 64 +: 32]), 64'd0);

    // random action lists
    for (int p = 0; p < 8; p++) begin
      new_pkt();
      for (int i = 0; i < NACT; i++) acts[i] = 16'($urandom);
      run($sformatf("rnd%0d", p));
    end

    // back-to-back: one packet per 18 cycles
    new_pkt(); acts[3] = mk_act(7, 3, 4, 1);
    ea = model_phv(); drive(); segs_valid = 1'b1;
    wait_valid(cyc, rc, ra);
    chk("thr.lat0", 64'(cyc), 64'd17);
    chk_phv("thr.a", ea);
    new_pkt(); for (int i = 0; i < NACT; i++) acts[i] = 16'($urandom);
    eb = model_phv(); drive();
    @(posedge axis_clk); #1;
    wait_valid(cyc, rc, ra);
    chk("thr.period", 64'(cyc + 1), 64'd18);
    chk_phv("thr.b", eb);
    segs_valid = 1'b0;
    @(posedge axis_clk); #1;

    // downstream stall with a new packet already waiting
    new_pkt(); for (int i = 0; i < NACT; i++) acts[i] = 16'($urandom);
    ea = model_phv(); drive(); segs_valid = 1'b1; stg_ready_in = 1'b0;
    wait_valid(cyc, rc, ra);
    chk("stl.lat", 64'(cyc), 64'd17);
    new_pkt(); for (int i = 0; i < NACT; i++) acts[i] = 16'($urandom);
    eb = model_phv(); drive();
    for (int s = 0; s < 10; s++) begin
      @(posedge axis_clk); #1;
      chk("stl.pv", 64'(parser_valid), 64'd1);
      chk("stl.sr", 64'(segs_ready), 64'd0);
      chk_phv("stl", ea);
    end
    stg_ready_in = 1'b1;
    @(posedge axis_clk); #1;
    chk("stl.drop", 64'(parser_valid), 64'd0);
    wait_valid(cyc, rc, ra);
    chk("stl.next_lat", 64'(cyc), 64'd17);
    chk_phv("stl.next", eb);
    segs_valid = 1'b0;
    @(posedge axis_clk); #1;

    // VLAN consumer stall
    new_pkt(); for (int i = 0; i < NACT; i++) acts[i] = 16'($urandom);
    ea = model_phv(); va = model_vlan(); drive(); segs_valid = 1'b1; out_vlan_ready = 1'b0;
    wait_valid(cyc, rc, ra);
    chk("vst.lat", 64'(cyc), 64'd17);
    chk_phv("vst", ea);
    new_pkt(); for (int i = 0; i < NACT; i++) acts[i] = 16'($urandom);
    eb = model_phv(); drive();
`ifdef PARSER_VLAN_OUT_EN
    for (int s = 0; s < 5; s++) begin
      @(posedge axis_clk); #1;
      chk("vst.pv", 64'(parser_valid), 64'd0);
      chk("vst.ovv", 64'(out_vlan_valid), 64'd1);
      chk("vst.ov", 64'(out_vlan), 64'(va));
      chk("vst.sr", 64'(segs_ready), 64'd0);
    end
    out_vlan_ready = 1'b1;
    @(posedge axis_clk); #1;
    chk("vst.ovv_drop", 64'(out_vlan_valid), 64'd0);
`else
    @(posedge axis_clk); #1;
    chk("vst.pv", 64'(parser_valid), 64'd0);
    chk("vst.ovv", 64'(out_vlan_valid), 64'd0);
    chk("vst.ov", 64'(out_vlan), 64'd0);
    out_vlan_ready = 1'b1;
`endif
    wait_valid(cyc, rc, ra);
    chk("vst.next_lat", 64'(cyc), 64'd17);
    chk_phv("vst.next", eb);
    segs_valid = 1'b0;
    @(posedge axis_clk); #1;

    // reset in the middle of WALK, then re-present
    new_pkt(); for (int i = 0; i < NACT; i++) acts[i] = 16'($urandom);
    ea = model_phv(); drive(); segs_valid = 1'b1;
    repeat (5) @(posedge axis_clk);
    #3 aresetn = 1'b0;
    #1;
    chk("rw.pv", 64'(parser_valid), 64'd0);
    chk("rw.sr", 64'(segs_ready), 64'd0);
    chk("rw.ovv", 64'(out_vlan_valid), 64'd0);
    chk("rw.ov", 64'(out_vlan), 64'd0);
    chk_phv("rw", '0);
    @(negedge axis_clk) aresetn = 1'b1;
    wait_valid(cyc, rc, ra);
    chk("rw.lat", 64'(cyc), 64'd17);
    chk("rw.rdy_cnt", 64'(rc), 64'd1);
    chk_phv("rw.again", ea);
    segs_valid = 1'b0;
    @(posedge axis_clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
